// File: rtl/wb_arbiter.sv
// Write-back arbiter: grants one of NREQ requesters onto the register-file write port
// and tracks pending destination writes in a 32-entry scoreboard indexed {gfflag,num}.
module wb_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter bit          RR_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_gfflag,
    input  logic [4*NREQ-1:0]    req_num,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic                 wb_hold,
    input  logic                 rsv_valid,
    input  logic                 rsv_gfflag,
    input  logic [3:0]           rsv_num,
    output logic                 w_gfflag,
    output logic [3:0]           w_num,
    output logic [31:0]          w_data,
    output logic                 w_enable,
    output logic [2:0]           grant_id,
    output logic [31:0]          busy
);

    localparam int unsigned IDW  = 3;
    localparam int unsigned NUMW = 4;
    localparam int unsigned DATW = 32;
    localparam int unsigned BSYW = 32;

    logic [IDW-1:0]  r_ptr;
    logic            r_wr_en;
    logic            r_wr_gf;
    logic [NUMW-1:0] r_wr_num;
    logic [DATW-1:0] r_wr_data;
    logic [IDW-1:0]  r_gnt_id;
    logic [BSYW-1:0] r_busy;

    logic [IDW-1:0]  w_ptr_eff;
    logic [IDW-1:0]  w_gidx;
    logic [IDW-1:0]  w_ptr_nxt;
    logic            w_hs;
    logic [NREQ-1:0] w_ready;
    logic            w_sel_gf;
    logic [NUMW-1:0] w_sel_num;
    logic [DATW-1:0] w_sel_data;
    logic [BSYW-1:0] w_set;
    logic [BSYW-1:0] w_clr;

    // First valid requester found searching upward from start, wrapping at NREQ-1.
    function automatic logic [IDW-1:0] f_pick(input logic [NREQ-1:0] valid,
                                              input logic [IDW-1:0]  start);
        logic [IDW-1:0] sel;
        logic           hit;
        int unsigned    idx;
        sel = '0;
        hit = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(start) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!hit && (((valid >> idx) & NREQ'(1)) != '0)) begin
                hit = 1'b1;
                sel = IDW'(idx);
            end
        end
        return sel;
    endfunction

    // Combinational grant and payload selection; ready is held low during reset.
    always_comb begin
        w_ptr_eff  = RR_EN ? r_ptr : '0;
        w_hs       = rstn && !wb_hold && (|req_valid);
        w_gidx     = f_pick(req_valid, w_ptr_eff);
        w_ready    = w_hs ? (NREQ'(1) << w_gidx) : '0;
        w_ptr_nxt  = (32'(w_gidx) + 32'd1 >= NREQ) ? '0 : (w_gidx + IDW'(1));
        w_sel_gf   = ((req_gfflag >> w_gidx) & NREQ'(1)) != '0;
        w_sel_num  = NUMW'(req_num >> (NUMW * 32'(w_gidx)));
        w_sel_data = DATW'(req_data >> (DATW * 32'(w_gidx)));
    end

    assign req_ready = w_ready;

    // Scoreboard masks: a same-index set overrides the clear below.
    always_comb begin
        w_set = rsv_valid ? (BSYW'(1) << {rsv_gfflag, rsv_num}) : '0;
        w_clr = r_wr_en   ? (BSYW'(1) << {r_wr_gf, r_wr_num})   : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (RR_EN && w_hs) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Write port register: payload holds its last value when nothing is granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_en   <= 1'b0;
            r_wr_gf   <= 1'b0;
            r_wr_num  <= '0;
            r_wr_data <= '0;
            r_gnt_id  <= '0;
        end else begin
            r_wr_en <= w_hs;
            if (w_hs) begin
                r_wr_gf   <= w_sel_gf;
                r_wr_num  <= w_sel_num;
                r_wr_data <= w_sel_data;
                r_gnt_id  <= w_gidx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign w_enable = r_wr_en;
    assign w_gfflag = r_wr_gf;
    assign w_num    = r_wr_num;
    assign w_data   = r_wr_data;
    assign grant_id = r_gnt_id;
    assign busy     = r_busy;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  req_valid;
    logic [2:0]  req_gfflag;
    logic [11:0] req_num;
    logic [95:0] req_data;
    logic        wb_hold;
    logic        rsv_valid;
    logic        rsv_gfflag;
    logic [3:0]  rsv_num;

    logic [2:0]  rr_ready, fp_ready;
    logic        rr_gf, fp_gf;
    logic [3:0]  rr_num, fp_num;
    logic [31:0] rr_data, fp_data;
    logic        rr_en, fp_en;
    logic [2:0]  rr_gid, fp_gid;
    logic [31:0] rr_busy, fp_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.NREQ(3), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rr_ready),
        .req_gfflag(req_gfflag), .req_num(req_num), .req_data(req_data),
        .wb_hold(wb_hold), .rsv_valid(rsv_valid), .rsv_gfflag(rsv_gfflag), .rsv_num(rsv_num),
        .w_gfflag(rr_gf), .w_num(rr_num), .w_data(rr_data), .w_enable(rr_en),
        .grant_id(rr_gid), .busy(rr_busy)
    );

    wb_arbiter #(.NREQ(3), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(fp_ready),
        .req_gfflag(req_gfflag), .req_num(req_num), .req_data(req_data),
        .wb_hold(wb_hold), .rsv_valid(rsv_valid), .rsv_gfflag(rsv_gfflag), .rsv_num(rsv_num),
        .w_gfflag(fp_gf), .w_num(fp_num), .w_data(fp_data), .w_enable(fp_en),
        .grant_id(fp_gid), .busy(fp_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_id;
        rstn       = 1'b0;
        req_valid  = 3'b111;
        req_gfflag = '0;
        req_num    = '0;
        req_data   = '0;
        wb_hold    = 1'b0;
        rsv_valid  = 1'b0;
        rsv_gfflag = 1'b0;
        rsv_num    = '0;

        // Reset with all requesters valid
        #2;
        chk("rst_ready_rr", 32'(rr_ready), 32'h0);
        chk("rst_ready_fp", 32'(fp_ready), 32'h0);
        chk("rst_wen", 32'(rr_en), 32'h0);
        chk("rst_busy", rr_busy, 32'h0);
        tick(); tick();
        chk("rst_ready_hold", 32'(rr_ready), 32'h0);
        chk("rst_wen_hold", 32'(rr_en), 32'h0);
        chk("rst_gid", 32'(rr_gid), 32'h0);
        chk("rst_wdata", rr_data, 32'h0);
        req_valid = '0;
        rstn      = 1'b1;

        // Single request from requester 1
        req_valid       = 3'b010;
        req_num[7:4]    = 4'd5;
        req_data[63:32] = 32'hDEADBEEF;
        #1;
        chk("single_ready", 32'(rr_ready), 32'h2);
        tick();
        chk("single_wen", 32'(rr_en), 32'h1);
        chk("single_wnum", 32'(rr_num), 32'h5);
        chk("single_wdata", rr_data, 32'hDEADBEEF);
        chk("single_gid", 32'(rr_gid), 32'h1);
        chk("single_wgf", 32'(rr_gf), 32'h0);
        req_valid = '0;
        #1;
        chk("single_ready_off", 32'(rr_ready), 32'h0);
        tick();
        chk("single_wen_off", 32'(rr_en), 32'h0);
        chk("single_wnum_hold", 32'(rr_num), 32'h5);
        chk("single_wdata_hold", rr_data, 32'hDEADBEEF);
        chk("single_gid_hold", 32'(rr_gid), 32'h1);

        // Reset pulse returns the round-robin pointer to 0
        rstn = 1'b0;
        tick();
        rstn = 1'b1;

        // All three valid for six cycles
        req_num   = {4'd2, 4'd1, 4'd0};
        req_data  = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        req_valid = 3'b111;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_id = i % 3;
            chk("rr_ready", 32'(rr_ready), 32'(1) << exp_id);
            chk("fp_ready", 32'(fp_ready), 32'h1);
            tick();
            chk("rr_gid", 32'(rr_gid), 32'(exp_id));
            chk("rr_wen", 32'(rr_en), 32'h1);
            chk("rr_wdata", rr_data, 32'h0000_00A0 + 32'(exp_id));
            chk("fp_gid", 32'(fp_gid), 32'h0);
            chk("fp_wen", 32'(fp_en), 32'h1);
        end
        req_valid = '0;
        tick();
        chk("rr_idle_wen", 32'(rr_en), 32'h0);

        // Scoreboard: reserve f3, then write it back
        rsv_valid  = 1'b1;
        rsv_gfflag = 1'b1;
        rsv_num    = 4'd3;
        tick();
        rsv_valid = 1'b0;
        chk("sb_set19", rr_busy, 32'h0008_0000);
        req_valid    = 3'b001;
        req_gfflag   = 3'b001;
        req_num[3:0] = 4'd3;
        tick();
        req_valid  = '0;
        req_gfflag = '0;
        chk("sb_wr_wen", 32'(rr_en), 32'h1);
        chk("sb_wr_wgf", 32'(rr_gf), 32'h1);
        chk("sb_busy_before_clr", rr_busy, 32'h0008_0000);
        tick();
        chk("sb_clr19", rr_busy, 32'h0);

        // Same-edge reserve and write-back of r7: set wins
        rsv_valid  = 1'b1;
        rsv_gfflag = 1'b0;
        rsv_num    = 4'd7;
        tick();
        rsv_valid = 1'b0;
        chk("sb_set7", rr_busy, 32'h0000_0080);
        req_valid    = 3'b010;
        req_num[7:4] = 4'd7;
        tick();
        req_valid = '0;
        chk("sb_wr7_num", 32'(rr_num), 32'h7);
        rsv_valid = 1'b1;
        tick();
        rsv_valid = 1'b0;
        chk("sb_same_edge", rr_busy, 32'h0000_0080);
        chk("fp_same_edge", fp_busy, 32'h0000_0080);

        // Different indices on one edge: clear r7, set r2
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        rsv_valid = 1'b1;
        rsv_num   = 4'd2;
        tick();
        rsv_valid = 1'b0;
        chk("sb_diff_idx", rr_busy, 32'h0000_0004);

        // Hold blocks grants for three cycles
        wb_hold         = 1'b1;
        req_valid       = 3'b001;
        req_num[3:0]    = 4'd9;
        req_data[31:0]  = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready_rr", 32'(rr_ready), 32'h0);
            chk("hold_ready_fp", 32'(fp_ready), 32'h0);
            tick();
            chk("hold_wen", 32'(rr_en), 32'h0);
        end
        wb_hold = 1'b0;
        #1;
        chk("hold_rel_ready", 32'(rr_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("hold_rel_wen", 32'(rr_en), 32'h1);
        chk("hold_rel_gid", 32'(rr_gid), 32'h0);
        chk("hold_rel_wdata", rr_data, 32'h0000_0055);
        chk("hold_rel_wnum", 32'(rr_num), 32'h9);

        // Reset mid-stream with a write in flight and busy = 0x21
        rstn = 1'b0;
        tick();
        rstn      = 1'b1;
        rsv_valid = 1'b1;
        rsv_num   = 4'd0;
        tick();
        rsv_num = 4'd5;
        tick();
        rsv_valid = 1'b0;
        chk("mid_busy_pre", rr_busy, 32'h0000_0021);
        req_valid = 3'b001;
        tick();
        chk("mid_wen_pre", 32'(rr_en), 32'h1);
        chk("mid_busy_inflight", rr_busy, 32'h0000_0021);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_wen_rst", 32'(rr_en), 32'h0);
        chk("mid_busy_rst", rr_busy, 32'h0);
        chk("mid_ready_rst", 32'(rr_ready), 32'h0);
        tick();
        chk("mid_wen_rst_hold", 32'(rr_en), 32'h0);
        rstn      = 1'b1;
        req_valid = 3'b111;
        #1;
        chk("mid_ptr0_rr", 32'(rr_ready), 32'h1);
        chk("mid_ptr0_fp", 32'(fp_ready), 32'h1);
        req_valid        = 3'b100;
        req_num[11:8]    = 4'd2;
        req_data[95:64]  = 32'h0000_00C2;
        #1;
        chk("mid_req2_ready", 32'(rr_ready), 32'h4);
        tick();
        req_valid = '0;
        chk("mid_req2_gid", 32'(rr_gid), 32'h2);
        chk("mid_req2_wen", 32'(rr_en), 32'h1);
        chk("mid_req2_wdata", rr_data, 32'h0000_00C2);
        tick();
        chk("mid_req2_wen_off", 32'(rr_en), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
